// File: rtl/memory_controller_if.sv
// Load/store, instruction-fetch and byte-wide RAM signals of the memory controller.
// slave = controller side, master = requesters plus RAM.
interface memory_controller_if #(parameter int ADDR_WIDTH = 32);
  logic                  lsb_request_in;
  logic                  lsb_rw_in;
  logic [ADDR_WIDTH-1:0] lsb_address_in;
  logic [2:0]            lsb_goal_in;
  logic [31:0]           lsb_data_in;
  logic                  lsb_ready_out;
  logic [31:0]           lsb_data_out;
  logic                  if_request_in;
  logic [ADDR_WIDTH-1:0] if_address_in;
  logic                  if_ready_out;
  logic [31:0]           if_data_out;
  logic [7:0]            mem_din_in;
  logic [7:0]            mem_dout_out;
  logic [ADDR_WIDTH-1:0] mem_a_out;
  logic                  mem_wr_out;

  modport slave (
    input  lsb_request_in, lsb_rw_in, lsb_address_in, lsb_goal_in, lsb_data_in,
    input  if_request_in, if_address_in, mem_din_in,
    output lsb_ready_out, lsb_data_out, if_ready_out, if_data_out,
    output mem_dout_out, mem_a_out, mem_wr_out
  );

  modport master (
    output lsb_request_in, lsb_rw_in, lsb_address_in, lsb_goal_in, lsb_data_in,
    output if_request_in, if_address_in, mem_din_in,
    input  lsb_ready_out, lsb_data_out, if_ready_out, if_data_out,
    input  mem_dout_out, mem_a_out, mem_wr_out
  );
endinterface

// File: rtl/memory_controller.sv
// Serialises LSB loads/stores and instruction fetches onto a byte-wide synchronous RAM.
// One-deep pending slot per requester; LSB wins ties; ready pulses carry zero-extended data.
module memory_controller #(
  parameter int ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  memory_controller_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]            state_q;
  logic                  lsb_full_q, lsb_rw_q, if_full_q, owner_if_q;
  logic [ADDR_WIDTH-1:0] lsb_addr_q, if_addr_q, base_q, mem_a_q;
  logic [2:0]            lsb_goal_q, n_q, cnt_q;
  logic [31:0]           lsb_wdata_q, wdata_q, word_q, lsb_data_q, if_data_q;
  logic [7:0]            dout_q;
  logic                  wr_q, lsb_ready_q, if_ready_q;

  // A pulse seen in an idle cycle is used directly so it starts at the same edge.
  logic                  lsb_pend, if_pend, start_lsb, start_if;
  logic                  lsb_rw_e;
  logic [ADDR_WIDTH-1:0] lsb_addr_e, if_addr_e, a_nxt;
  logic [2:0]            lsb_goal_e, cnt_nxt;
  logic [31:0]           lsb_wdata_e, word_nxt;
  logic [1:0]            cap_idx;

  function automatic logic [2:0] goal_len(input logic [2:0] g);
    case (g)
      3'd4:    return 3'd4;
      3'd2:    return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  always_comb begin
    lsb_pend    = bus.lsb_request_in | lsb_full_q;
    if_pend     = bus.if_request_in | if_full_q;
    lsb_rw_e    = bus.lsb_request_in ? bus.lsb_rw_in      : lsb_rw_q;
    lsb_addr_e  = bus.lsb_request_in ? bus.lsb_address_in : lsb_addr_q;
    lsb_goal_e  = bus.lsb_request_in ? bus.lsb_goal_in    : lsb_goal_q;
    lsb_wdata_e = bus.lsb_request_in ? bus.lsb_data_in    : lsb_wdata_q;
    if_addr_e   = bus.if_request_in  ? bus.if_address_in  : if_addr_q;
    start_lsb   = (state_q == IDLE) && lsb_pend;
    start_if    = (state_q == IDLE) && !lsb_pend && if_pend;
    cnt_nxt     = cnt_q + 3'd1;
    a_nxt       = base_q + ADDR_WIDTH'(cnt_nxt);
    cap_idx     = 2'(cnt_q - 3'd1);
    // Byte presented last cycle lands in its little-endian lane.
    word_nxt    = word_q;
    if (cnt_q != 3'd0) word_nxt[{cap_idx, 3'b000} +: 8] = bus.mem_din_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lsb_full_q  <= 1'b0;
      lsb_rw_q    <= 1'b0;
      lsb_addr_q  <= '0;
      lsb_goal_q  <= '0;
      lsb_wdata_q <= '0;
      if_full_q   <= 1'b0;
      if_addr_q   <= '0;
      owner_if_q  <= 1'b0;
      base_q      <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      mem_a_q     <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      lsb_ready_q <= 1'b0;
      if_ready_q  <= 1'b0;
      lsb_data_q  <= '0;
      if_data_q   <= '0;
    end else begin
      lsb_ready_q <= 1'b0;
      if_ready_q  <= 1'b0;
      if (bus.lsb_request_in) begin
        lsb_full_q  <= 1'b1;
        lsb_rw_q    <= bus.lsb_rw_in;
        lsb_addr_q  <= bus.lsb_address_in;
        lsb_goal_q  <= bus.lsb_goal_in;
        lsb_wdata_q <= bus.lsb_data_in;
      end
      if (bus.if_request_in) begin
        if_full_q <= 1'b1;
        if_addr_q <= bus.if_address_in;
      end
      if (start_lsb) lsb_full_q <= 1'b0;
      if (start_if)  if_full_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_lsb) begin
            base_q     <= lsb_addr_e;
            mem_a_q    <= lsb_addr_e;
            n_q        <= goal_len(lsb_goal_e);
            cnt_q      <= '0;
            owner_if_q <= 1'b0;
            word_q     <= '0;
            wdata_q    <= lsb_wdata_e;
            if (lsb_rw_e) begin
              state_q <= WRITE;
              dout_q  <= lsb_wdata_e[7:0];
              wr_q    <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end else if (start_if) begin
            base_q     <= if_addr_e;
            mem_a_q    <= if_addr_e;
            n_q        <= 3'd4;
            cnt_q      <= '0;
            owner_if_q <= 1'b1;
            word_q     <= '0;
            state_q    <= READ;
          end
        end
        READ: begin
          word_q <= word_nxt;
          if (cnt_q == n_q) begin
            state_q <= IDLE;
            if (owner_if_q) begin
              if_data_q  <= word_nxt;
              if_ready_q <= 1'b1;
            end else begin
              lsb_data_q  <= word_nxt;
              lsb_ready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_nxt;
            if (cnt_nxt < n_q) mem_a_q <= a_nxt;
          end
        end
        WRITE: begin
          if (cnt_nxt == n_q) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            lsb_ready_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_nxt;
            mem_a_q <= a_nxt;
            dout_q  <= wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
          end
        end
        default: begin
          state_q <= IDLE;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lsb_ready_out = lsb_ready_q;
  assign bus.lsb_data_out  = lsb_data_q;
  assign bus.if_ready_out  = if_ready_q;
  assign bus.if_data_out   = if_data_q;
  assign bus.mem_a_out     = mem_a_q;
  assign bus.mem_dout_out  = dout_q;
  assign bus.mem_wr_out    = wr_q;
endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: stimulus queues expected responses and
// RAM writes, a negedge monitor pops and compares them against the DUT.
module tb_memory_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_controller_if #(.ADDR_WIDTH(32)) bus();
  memory_controller #(.ADDR_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [31:0] data; int cyc; bit chk; } rsp_t;
  typedef struct { logic [31:0] addr; logic [7:0] b; int cyc; } wr_t;

  logic [7:0] ram [0:4095];
  int   cyc = 0;
  int   npass = 0;
  int   ntot = 0;
  rsp_t lsb_q[$];
  rsp_t if_q[$];
  wr_t  wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Synchronous byte RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    cyc++;
    if (bus.mem_wr_out) ram[bus.mem_a_out[11:0]] <= bus.mem_dout_out;
    bus.mem_din_in <= ram[bus.mem_a_out[11:0]];
  end

  always @(negedge clk) begin : monitor
    rsp_t r;
    wr_t  w;
    if (!rst) begin
      if (bus.lsb_ready_out) begin
        if (lsb_q.size() == 0) check("lsb_unexpected_ready", 32'd1, 32'd0);
        else begin
          r = lsb_q.pop_front();
          check("lsb_ready_cycle", cyc, r.cyc);
          if (r.chk) check("lsb_data", bus.lsb_data_out, r.data);
        end
      end
      if (bus.if_ready_out) begin
        if (if_q.size() == 0) check("if_unexpected_ready", 32'd1, 32'd0);
        else begin
          r = if_q.pop_front();
          check("if_ready_cycle", cyc, r.cyc);
          check("if_data", bus.if_data_out, r.data);
        end
      end
      if (bus.mem_wr_out) begin
        if (wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          w = wr_q.pop_front();
          check("write_cycle", cyc, w.cyc);
          check("write_addr", bus.mem_a_out, w.addr);
          check("write_byte", {24'd0, bus.mem_dout_out}, {24'd0, w.b});
        end
      end
    end
  end

  task automatic push_lsb(input logic [31:0] d, input int c, input bit chk);
    rsp_t r;
    r.data = d; r.cyc = c; r.chk = chk;
    lsb_q.push_back(r);
  endtask

  task automatic push_if(input logic [31:0] d, input int c);
    rsp_t r;
    r.data = d; r.cyc = c; r.chk = 1'b1;
    if_q.push_back(r);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] b, input int c);
    wr_t w;
    w.addr = a; w.b = b; w.cyc = c;
    wr_q.push_back(w);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the request pulses for exactly one cycle; entered and left at #1 after posedge.
  task automatic drive(input bit lr, input bit rw, input logic [31:0] a, input logic [2:0] g,
                       input logic [31:0] d, input bit ir, input logic [31:0] ia);
    bus.lsb_request_in = lr;
    bus.lsb_rw_in      = rw;
    bus.lsb_address_in = a;
    bus.lsb_goal_in    = g;
    bus.lsb_data_in    = d;
    bus.if_request_in  = ir;
    bus.if_address_in  = ia;
    wait_cyc(1);
    bus.lsb_request_in = 1'b0;
    bus.if_request_in  = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_lsb_ready"}, {31'd0, bus.lsb_ready_out}, 32'd0);
    check({tag, "_if_ready"},  {31'd0, bus.if_ready_out},  32'd0);
    check({tag, "_lsb_data"},  bus.lsb_data_out, 32'd0);
    check({tag, "_if_data"},   bus.if_data_out,  32'd0);
    check({tag, "_mem_a"},     bus.mem_a_out,    32'd0);
    check({tag, "_mem_dout"},  {24'd0, bus.mem_dout_out}, 32'd0);
    check({tag, "_mem_wr"},    {31'd0, bus.mem_wr_out},   32'd0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'h000] = 8'h10; ram[12'h001] = 8'h20; ram[12'h002] = 8'h30; ram[12'h003] = 8'h40;
    ram[12'hFFF] = 8'hAB;
    bus.lsb_request_in = 1'b0; bus.lsb_rw_in = 1'b0; bus.lsb_address_in = '0;
    bus.lsb_goal_in = '0; bus.lsb_data_in = '0; bus.if_request_in = 1'b0; bus.if_address_in = '0;

    wait_cyc(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    wait_cyc(2);

    // LW / LB / LH loads
    t = cyc; push_lsb(32'h44332211, t + 6, 1'b1); drive(1, 0, 32'h100, 3'd4, 0, 0, 0); wait_cyc(8);
    t = cyc; push_lsb(32'h00000033, t + 3, 1'b1); drive(1, 0, 32'h102, 3'd1, 0, 0, 0); wait_cyc(5);
    t = cyc; push_lsb(32'h00003322, t + 4, 1'b1); drive(1, 0, 32'h101, 3'd2, 0, 0, 0); wait_cyc(6);

    // SW then read back
    t = cyc;
    push_wr(32'h200, 8'hEF, t + 1); push_wr(32'h201, 8'hBE, t + 2);
    push_wr(32'h202, 8'hAD, t + 3); push_wr(32'h203, 8'hDE, t + 4);
    push_lsb(32'h0, t + 5, 1'b0);
    drive(1, 1, 32'h200, 3'd4, 32'hDEADBEEF, 0, 0); wait_cyc(7);
    t = cyc; push_lsb(32'hDEADBEEF, t + 6, 1'b1); drive(1, 0, 32'h200, 3'd4, 0, 0, 0); wait_cyc(8);

    // LH across the top of the address space wraps to 0
    t = cyc; push_lsb(32'h000010AB, t + 4, 1'b1); drive(1, 0, 32'hFFFF_FFFF, 3'd2, 0, 0, 0); wait_cyc(6);

    // Simultaneous LSB load and fetch: LSB first, fetch six cycles after its ready
    t = cyc;
    push_lsb(32'h44332211, t + 6, 1'b1);
    push_if(32'h40302010, t + 12);
    drive(1, 0, 32'h100, 3'd4, 0, 1, 32'h0); wait_cyc(14);

    // SH writes only the low two bytes of the store data
    t = cyc;
    push_wr(32'h204, 8'h66, t + 1); push_wr(32'h205, 8'h55, t + 2);
    push_lsb(32'h0, t + 3, 1'b0);
    drive(1, 1, 32'h204, 3'd2, 32'h11115566, 0, 0); wait_cyc(5);

    // Fetch pulse during a store is held until the store's ready cycle ends
    t = cyc;
    push_wr(32'h208, 8'h0D, t + 1); push_wr(32'h209, 8'hF0, t + 2);
    push_wr(32'h20A, 8'hFE, t + 3); push_wr(32'h20B, 8'hCA, t + 4);
    push_lsb(32'h0, t + 5, 1'b0);
    push_if(32'hDEADBEEF, t + 11);
    drive(1, 1, 32'h208, 3'd4, 32'hCAFEF00D, 0, 0);
    wait_cyc(1);
    drive(0, 0, 0, 3'd0, 0, 1, 32'h200);
    wait_cyc(12);

    t = cyc; push_lsb(32'h00000055, t + 3, 1'b1); drive(1, 0, 32'h205, 3'd1, 0, 0, 0); wait_cyc(5);
    t = cyc; push_lsb(32'hCAFEF00D, t + 6, 1'b1); drive(1, 0, 32'h208, 3'd4, 0, 0, 0); wait_cyc(8);

    // Reset during the third byte of a SW: only two bytes reach the RAM
    t = cyc;
    push_wr(32'h300, 8'h21, t + 1); push_wr(32'h301, 8'h43, t + 2);
    drive(1, 1, 32'h300, 3'd4, 32'h87654321, 0, 0);
    wait_cyc(2);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    t = cyc; push_lsb(32'h00004321, t + 6, 1'b1); drive(1, 0, 32'h300, 3'd4, 0, 0, 0);

    wait_cyc(10);
    check("lsb_queue_drained", lsb_q.size(), 32'd0);
    check("if_queue_drained",  if_q.size(),  32'd0);
    check("wr_queue_drained",  wr_q.size(),  32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/memory_controller.md
# memory_controller

Responder side of the load/store request interface, plus the instruction-fetch port. It serialises word, halfword and byte transfers onto the single-byte synchronous RAM port. It accepts one-cycle request pulses from the load/store buffer and the instruction fetcher, and latches each in a one-deep pending slot. It runs one transfer at a time, with the load/store buffer taking priority. On completion it returns a one-cycle ready pulse with zero-extended little-endian read data.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of request and RAM ports

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- lsb_request_in  input  1  one-cycle request pulse from load/store buffer
- lsb_rw_in  input  1  0 = load, 1 = store
- lsb_address_in  input  32  byte address of first byte
- lsb_goal_in  input  3  transfer size in bytes: 1, 2 or 4
- lsb_data_in  input  32  store data; low goal bytes written
- lsb_ready_out  output  1  one-cycle completion pulse (load and store)
- lsb_data_out  output  32  load result, zero-extended; valid while lsb_ready_out=1
- if_request_in  input  1  one-cycle fetch pulse
- if_address_in  input  32  fetch address; always 4 bytes
- if_ready_out  output  1  one-cycle fetch completion pulse
- if_data_out  output  32  fetched word; valid while if_ready_out=1
- mem_din_in  input  8  RAM read byte for address presented previous cycle
- mem_dout_out  output  8  RAM write byte
- mem_a_out  output  32  RAM byte address
- mem_wr_out  output  1  1 = write this cycle

## Operation
- Pending slots: each request pulse latches its address, size, rw and data into that requester's slot.
  - A pulse arriving while the slot is already full overwrites the slot; requesters never do this.
- States: IDLE, READ, WRITE.
- IDLE:
  - If the LSB slot is full, start its transfer.
  - Otherwise, if the IF slot is full, start a 4-byte READ.
  - A pulse arriving in an IDLE cycle is started at that same edge; it does not wait an extra cycle.
  - Starting a transfer clears the owning slot and loads the base address, the byte count N (goal 4→4, 2→2, otherwise 1) and the byte index k=0.
- READ:
  - Present base+k on mem_a_out for k=0..N-1, one byte per cycle, with mem_wr_out=0.
  - mem_din_in in the following cycle is byte k; store it in bits [8k+7:8k].
  - When byte N-1 is captured: register the assembled word, zero upper bytes, pulse the owner's ready and return to IDLE.
- WRITE:
  - Present base+k with mem_dout_out=lsb_data_in byte k and mem_wr_out=1, for N cycles.
  - Then pulse lsb_ready_out and return to IDLE.
  - mem_wr_out=0 in every non-write cycle.
- Address arithmetic is modulo 2^32; base+k wraps from 0xFFFFFFFF to 0. Misaligned addresses need no special handling.
- Data outputs hold their last value until the next completion for the same port.

## Timing
- Request pulse sampled at the end of cycle T with the controller idle: the first RAM address is driven in cycle T+1.
- Load of N bytes: addresses in cycles T+1..T+N; lsb_ready_out/lsb_data_out valid in cycle T+N+2.
  - LB: T+3. LH: T+4. LW/fetch: T+6.
- Store of N bytes: writes in cycles T+1..T+N; lsb_ready_out in cycle T+N+1.
- A new transfer may start at the edge ending a ready cycle; the load/store buffer reissues in the cycle after ready.
- Simultaneous LSB and IF pulses: LSB served first; IF starts at the edge that ends the LSB transfer's ready cycle.
- Reset values:
  - state=IDLE, both slots empty.
  - All outputs 0: lsb_ready_out, if_ready_out, lsb_data_out, if_data_out, mem_a_out, mem_dout_out, mem_wr_out.
- Reset asserted mid-transfer: the transfer is abandoned, mem_wr_out drops immediately, and no ready pulse is issued. Pending requests are lost.

## Test plan
- RAM[0x100..0x103]=0x11,0x22,0x33,0x44; LW pulse at 0x100 → lsb_ready_out one cycle, 5 cycles after the pulse cycle, with lsb_data_out=0x44332211.
- LB at 0x102 → lsb_data_out=0x00000033, 2 cycles after the pulse cycle. LH at 0x101 → 0x00003322 with no alignment fault.
- SW 0xDEADBEEF at 0x200 → mem_wr_out high exactly 4 cycles writing EF,BE,AD,DE to 0x200..0x203, then lsb_ready_out. A subsequent LW at 0x200 returns 0xDEADBEEF.
- Same-cycle LSB LW at 0x100 and IF fetch at 0x0 → LSB ready first. The IF fetch starts right after and if_ready_out follows exactly 6 cycles later with the correct word. Neither ready pulse lasts more than one cycle.
- IF pulse while an LSB store is in progress → the fetch is latched, starts right after the store ready, and no request is lost.
- Assert rst during the third byte of a SW → mem_wr_out=0 asynchronously, no ready pulse, and all outputs 0. A fresh LW after reset completes normally.
